// File: rtl/endpoint_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// endpoint_mmio_ctrl
//   Memory-mapped front-end between the peripheral bus port and the TX/RX
//   engines. Holds NUM_CHAN TX staging FIFOs, one RX FIFO, a round-robin
//   send-request arbiter and a maskable status/interrupt block.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   addr/wen/ren/wdata  : bus request (word-aligned addresses)
//   rdata/error/        : bus response, combinational in the request cycle
//   request_stall
//   tx_ren/tx_rdata/    : per-channel TX FIFO pop, head word and empty flag
//   tx_empty
//   send_valid/chan/msg : pending send request toward the TX engine
//   send_ready          : TX engine accepts the presented request
//   rx_wen/rx_wdata     : RX engine push
//   rx_full             : RX FIFO full
//   config_done         : configuration-complete flag (readable)
//   irq                 : registered interrupt, |(status & mask)
// -----------------------------------------------------------------------------
module endpoint_mmio_ctrl #(
    parameter int NUM_CHAN      = 4,
    parameter int NUM_MSGS      = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int STALL_ON_FULL = 0,
    localparam int CW = ($clog2(NUM_CHAN) > 0) ? $clog2(NUM_CHAN) : 1,
    localparam int MW = ($clog2(NUM_MSGS) > 0) ? $clog2(NUM_MSGS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    addr,
    input  logic                           wen,
    input  logic                           ren,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata,
    output logic                           error,
    output logic                           request_stall,
    input  logic [NUM_CHAN-1:0]            tx_ren,
    output logic [NUM_CHAN*DATA_WIDTH-1:0] tx_rdata,
    output logic [NUM_CHAN-1:0]            tx_empty,
    output logic                           send_valid,
    output logic [CW-1:0]                  send_chan,
    output logic [MW-1:0]                  send_msg,
    input  logic                           send_ready,
    input  logic                           rx_wen,
    input  logic [DATA_WIDTH-1:0]          rx_wdata,
    output logic                           rx_full,
    input  logic                           config_done,
    output logic                           irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    localparam logic [31:0] A_RX_DATA = 32'h0000_1000;
    localparam logic [31:0] A_RX_CNT  = 32'h0000_1004;
    localparam logic [31:0] A_STATUS  = 32'h0000_1008;
    localparam logic [31:0] A_MASK    = 32'h0000_100C;
    localparam logic [31:0] A_CONFIG  = 32'h0000_1010;
    localparam logic [31:0] BAD_DATA  = 32'hBAD1_BAD1;

    // TX FIFO state
    logic [DATA_WIDTH-1:0] tx_mem_q  [NUM_CHAN][DEPTH];
    logic [PW-1:0]         tx_wptr_q [NUM_CHAN];
    logic [PW-1:0]         tx_wptr_d [NUM_CHAN];
    logic [PW-1:0]         tx_rptr_q [NUM_CHAN];
    logic [PW-1:0]         tx_rptr_d [NUM_CHAN];
    logic [NW-1:0]         tx_cnt_q  [NUM_CHAN];
    logic [NW-1:0]         tx_cnt_d  [NUM_CHAN];
    logic [NUM_CHAN-1:0]   tx_full_s;
    logic [NUM_CHAN-1:0]   tx_empty_s;
    logic [NUM_CHAN-1:0]   tx_push_s;
    logic [NUM_CHAN-1:0]   tx_pop_s;

    // RX FIFO state
    logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];
    logic [PW-1:0]         rx_wptr_q, rx_wptr_d;
    logic [PW-1:0]         rx_rptr_q, rx_rptr_d;
    logic [NW-1:0]         rx_cnt_q, rx_cnt_d;
    logic                  rx_empty_s;
    logic                  rx_push_s;
    logic                  rx_pop_s;
    logic                  ovr_set_s;

    // Arbiter state
    logic [NUM_CHAN-1:0]   pending_q, pending_d;
    logic [MW-1:0]         msg_q [NUM_CHAN];
    logic [MW-1:0]         msg_d [NUM_CHAN];
    logic [CW-1:0]         rr_q, rr_d;
    logic [CW-1:0]         grant_s;
    logic                  found_s;
    logic                  accept_s;
    logic [NUM_CHAN-1:0]   send_set_s;

    // Status / interrupt state
    logic                  ovr_q, ovr_d;
    logic                  sent_q, sent_d;
    logic [2:0]            mask_q, mask_d;
    logic                  irq_q, irq_d;
    logic [1:0]            w1c_s;
    logic                  mask_we_s;

    // Bus decode
    logic                  is_tx_s;
    logic                  is_send_s;
    logic [CW-1:0]         ch_s;

    // Decode the channel-indexed address windows (0x0000+4c and 0x0100+4c)
    always_comb begin
        ch_s      = CW'(addr[7:2]);
        is_tx_s   = (addr[31:8] == 24'h00_0000) && (addr[1:0] == 2'b00) &&
                    ({26'd0, addr[7:2]} < 32'(NUM_CHAN));
        is_send_s = (addr[31:8] == 24'h00_0001) && (addr[1:0] == 2'b00) &&
                    ({26'd0, addr[7:2]} < 32'(NUM_CHAN));
    end

    // FIFO level flags
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            tx_full_s[c]  = (tx_cnt_q[c] == NW'(DEPTH));
            tx_empty_s[c] = (tx_cnt_q[c] == NW'(0));
            tx_pop_s[c]   = tx_ren[c] & ~tx_empty_s[c];
        end
        rx_empty_s = (rx_cnt_q == NW'(0));
        rx_full    = (rx_cnt_q == NW'(DEPTH));
    end

    // Bus response and the side-effect strobes it produces
    always_comb begin
        rdata         = BAD_DATA;
        error         = 1'b0;
        request_stall = 1'b0;
        tx_push_s     = '0;
        send_set_s    = '0;
        rx_pop_s      = 1'b0;
        w1c_s         = 2'b00;
        mask_we_s     = 1'b0;
        if (wen && ren) begin
            error = 1'b1;
        end else if (wen) begin
            if (is_tx_s) begin
                // A full FIFO is never written; the stall/error choice is static
                if (tx_full_s[ch_s]) begin
                    if (STALL_ON_FULL != 0) begin
                        request_stall = 1'b1;
                    end else begin
                        error = 1'b1;
                    end
                end else begin
                    tx_push_s[ch_s] = 1'b1;
                end
            end else if (is_send_s) begin
                // Pending check uses the pre-acceptance view, so a same-cycle grant still stalls
                if (pending_q[ch_s]) begin
                    request_stall = 1'b1;
                end else if (tx_empty_s[ch_s] || (wdata >= 32'(NUM_MSGS))) begin
                    error = 1'b1;
                end else begin
                    send_set_s[ch_s] = 1'b1;
                end
            end else if (addr == A_STATUS) begin
                w1c_s = wdata[2:1];
            end else if (addr == A_MASK) begin
                mask_we_s = 1'b1;
            end else begin
                error = 1'b1;
            end
        end else if (ren) begin
            case (addr)
                A_RX_DATA: begin
                    if (rx_empty_s) begin
                        error = 1'b1;
                    end else begin
                        rdata    = 32'(rx_mem_q[rx_rptr_q]);
                        rx_pop_s = 1'b1;
                    end
                end
                A_RX_CNT: rdata = 32'(rx_cnt_q);
                A_STATUS: rdata = {29'd0, sent_q, ovr_q, ~rx_empty_s};
                A_MASK:   rdata = {29'd0, mask_q};
                A_CONFIG: rdata = {31'd0, config_done};
                default:  error = 1'b1;
            endcase
        end else begin
            rdata = BAD_DATA;
        end
    end

    // TX FIFO pointer and count next-state
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            tx_wptr_d[c] = tx_push_s[c] ? (tx_wptr_q[c] + PW'(1)) : tx_wptr_q[c];
            tx_rptr_d[c] = tx_pop_s[c]  ? (tx_rptr_q[c] + PW'(1)) : tx_rptr_q[c];
            case ({tx_push_s[c], tx_pop_s[c]})
                2'b10:   tx_cnt_d[c] = tx_cnt_q[c] + NW'(1);
                2'b01:   tx_cnt_d[c] = tx_cnt_q[c] - NW'(1);
                default: tx_cnt_d[c] = tx_cnt_q[c];
            endcase
        end
    end

    // RX FIFO next-state; a push into a full FIFO is dropped even if popped this cycle
    always_comb begin
        rx_push_s = rx_wen & ~rx_full;
        ovr_set_s = rx_wen & rx_full;
        rx_wptr_d = rx_push_s ? (rx_wptr_q + PW'(1)) : rx_wptr_q;
        rx_rptr_d = rx_pop_s  ? (rx_rptr_q + PW'(1)) : rx_rptr_q;
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_cnt_d = rx_cnt_q + NW'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - NW'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    // Round-robin grant: first pending channel at or after rr_q, wrapping
    always_comb begin
        grant_s = rr_q;
        found_s = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (!found_s && pending_q[CW'((int'(rr_q) + i) % NUM_CHAN)]) begin
                found_s = 1'b1;
                grant_s = CW'((int'(rr_q) + i) % NUM_CHAN);
            end else begin
                found_s = found_s;
            end
        end
        send_valid = |pending_q;
        send_chan  = grant_s;
        send_msg   = msg_q[grant_s];
        accept_s   = send_valid & send_ready;
    end

    // Arbiter, status and interrupt next-state
    always_comb begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            pending_d[c] = (pending_q[c] & ~(accept_s & (grant_s == CW'(c)))) | send_set_s[c];
            msg_d[c]     = send_set_s[c] ? wdata[MW-1:0] : msg_q[c];
        end
        if (accept_s) begin
            rr_d = (grant_s == CW'(NUM_CHAN - 1)) ? CW'(0) : (grant_s + CW'(1));
        end else begin
            rr_d = rr_q;
        end
        // Set events take priority over a same-cycle W1C
        ovr_d  = (ovr_q  & ~w1c_s[0]) | ovr_set_s;
        sent_d = (sent_q & ~w1c_s[1]) | accept_s;
        mask_d = mask_we_s ? wdata[2:0] : mask_q;
        irq_d  = |({sent_q, ovr_q, ~rx_empty_s} & mask_q);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                tx_wptr_q[c] <= '0;
                tx_rptr_q[c] <= '0;
                tx_cnt_q[c]  <= '0;
                msg_q[c]     <= '0;
            end
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
            pending_q <= '0;
            rr_q      <= '0;
            ovr_q     <= 1'b0;
            sent_q    <= 1'b0;
            mask_q    <= 3'b000;
            irq_q     <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                tx_wptr_q[c] <= tx_wptr_d[c];
                tx_rptr_q[c] <= tx_rptr_d[c];
                tx_cnt_q[c]  <= tx_cnt_d[c];
                msg_q[c]     <= msg_d[c];
            end
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_cnt_q  <= rx_cnt_d;
            pending_q <= pending_d;
            rr_q      <= rr_d;
            ovr_q     <= ovr_d;
            sent_q    <= sent_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    // FIFO storage; contents are don't-care while the counts say empty
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (tx_push_s[c]) begin
                tx_mem_q[c][tx_wptr_q[c]] <= wdata[DATA_WIDTH-1:0];
            end
        end
        if (rx_push_s) begin
            rx_mem_q[rx_wptr_q] <= rx_wdata;
        end
    end

    // Per-channel TX head and empty outputs
    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_tx_out
        assign tx_rdata[g*DATA_WIDTH +: DATA_WIDTH] = tx_mem_q[g][tx_rptr_q[g]];
        assign tx_empty[g] = tx_empty_s[g];
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_endpoint_mmio_ctrl.sv
`timescale 1ns/1ps
module tb_endpoint_mmio_ctrl;

    localparam logic [31:0] BAD = 32'hBAD1_BAD1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  addr, wdata, rdata;
    logic         wen, ren, error, request_stall;
    logic [3:0]   tx_ren, tx_empty;
    logic [127:0] tx_rdata;
    logic         send_valid, send_ready;
    logic [1:0]   send_chan, send_msg;
    logic         rx_wen, rx_full, config_done, irq;
    logic [31:0]  rx_wdata;

    // second instance, STALL_ON_FULL=1
    logic [31:0]  s_addr, s_wdata, s_rdata, s_rx_wdata;
    logic         s_wen, s_ren, s_error, s_request_stall;
    logic [3:0]   s_tx_ren, s_tx_empty;
    logic [127:0] s_tx_rdata;
    logic         s_send_valid, s_send_ready, s_rx_wen, s_rx_full, s_config_done, s_irq;
    logic [1:0]   s_send_chan, s_send_msg;

    always #5 clk = ~clk;

    endpoint_mmio_ctrl #(.STALL_ON_FULL(0)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wen(wen), .ren(ren), .wdata(wdata),
        .rdata(rdata), .error(error), .request_stall(request_stall),
        .tx_ren(tx_ren), .tx_rdata(tx_rdata), .tx_empty(tx_empty),
        .send_valid(send_valid), .send_chan(send_chan), .send_msg(send_msg),
        .send_ready(send_ready), .rx_wen(rx_wen), .rx_wdata(rx_wdata),
        .rx_full(rx_full), .config_done(config_done), .irq(irq)
    );

    endpoint_mmio_ctrl #(.STALL_ON_FULL(1)) dut_s (
        .clk(clk), .rst(rst), .addr(s_addr), .wen(s_wen), .ren(s_ren), .wdata(s_wdata),
        .rdata(s_rdata), .error(s_error), .request_stall(s_request_stall),
        .tx_ren(s_tx_ren), .tx_rdata(s_tx_rdata), .tx_empty(s_tx_empty),
        .send_valid(s_send_valid), .send_chan(s_send_chan), .send_msg(s_send_msg),
        .send_ready(s_send_ready), .rx_wen(s_rx_wen), .rx_wdata(s_rx_wdata),
        .rx_full(s_rx_full), .config_done(s_config_done), .irq(s_irq)
    );

    typedef struct packed { logic [31:0] rd; logic err; logic stall; } bus_exp_t;
    typedef struct packed { logic [1:0] ch; logic [1:0] msg; } send_exp_t;
    typedef struct packed { logic [1:0] ch; logic [31:0] data; } tx_exp_t;

    bus_exp_t  bus_q[$];
    string     bus_nm[$];
    send_exp_t send_q[$];
    tx_exp_t   tx_q[$];

    int checks = 0;
    int errors = 0;

    bus_exp_t  mb;
    string     mn;
    send_exp_t ms;
    tx_exp_t   mt;

    // scoreboard monitor: compares whenever the DUT presents a bus response, grant or TX pop
    always @(negedge clk) begin
        if (!rst) begin
            if (wen || ren) begin
                checks++;
                if (bus_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: addr=%h no expected response queued", addr);
                end else begin
                    mb = bus_q.pop_front();
                    mn = bus_nm.pop_front();
                    if (rdata !== mb.rd || error !== mb.err || request_stall !== mb.stall) begin
                        errors++;
                        $display("FAIL %s: got rdata=%h error=%b stall=%b, expected rdata=%h error=%b stall=%b",
                                 mn, rdata, error, request_stall, mb.rd, mb.err, mb.stall);
                    end
                end
            end
            if (send_valid && send_ready) begin
                checks++;
                if (send_q.size() == 0) begin
                    errors++;
                    $display("FAIL send_unexpected: chan=%0d msg=%0d", send_chan, send_msg);
                end else begin
                    ms = send_q.pop_front();
                    if (send_chan !== ms.ch || send_msg !== ms.msg) begin
                        errors++;
                        $display("FAIL send_grant: got chan=%0d msg=%0d, expected chan=%0d msg=%0d",
                                 send_chan, send_msg, ms.ch, ms.msg);
                    end
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (tx_ren[c]) begin
                    checks++;
                    if (tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_pop_unexpected: chan=%0d", c);
                    end else begin
                        mt = tx_q.pop_front();
                        if (int'(mt.ch) != c || tx_rdata[c*32 +: 32] !== mt.data) begin
                            errors++;
                            $display("FAIL tx_pop: chan=%0d got %h, expected chan=%0d data %h",
                                     c, tx_rdata[c*32 +: 32], mt.ch, mt.data);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input logic es, input string nm);
        wen = w; ren = r; addr = a; wdata = d;
        bus_q.push_back('{er, ee, es});
        bus_nm.push_back(nm);
        step();
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic wr_ok(input logic [31:0] a, input logic [31:0] d, input string nm);
        bus(1'b1, 1'b0, a, d, BAD, 1'b0, 1'b0, nm);
    endtask

    task automatic rd_ok(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus(1'b0, 1'b1, a, 32'd0, exp, 1'b0, 1'b0, nm);
    endtask

    task automatic tx_pop(input logic [1:0] c, input logic [31:0] d);
        tx_q.push_back('{c, d});
        tx_ren = 4'b0001 << c;
        step();
        tx_ren = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        wen = 1'b0; ren = 1'b0; addr = 32'd0; wdata = 32'd0; tx_ren = 4'd0;
        send_ready = 1'b0; rx_wen = 1'b0; rx_wdata = 32'd0; config_done = 1'b0;
        s_wen = 1'b0; s_ren = 1'b0; s_addr = 32'd0; s_wdata = 32'd0; s_tx_ren = 4'd0;
        s_send_ready = 1'b0; s_rx_wen = 1'b0; s_rx_wdata = 32'd0; s_config_done = 1'b0;

        // reset state
        #12;
        check("rst_rdata", rdata, BAD);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_stall", {31'd0, request_stall}, 32'd0);
        check("rst_send_valid", {31'd0, send_valid}, 32'd0);
        check("rst_tx_empty", {28'd0, tx_empty}, 32'hF);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        step();

        // two channels pending, round robin from 0
        wr_ok(32'h0000, 32'h10, "tx0_push");
        wr_ok(32'h0008, 32'h20, "tx2_push");
        wr_ok(32'h0100, 32'd1, "send0");
        wr_ok(32'h0108, 32'd3, "send2");
        bus(1'b1, 1'b0, 32'h0100, 32'd2, BAD, 1'b0, 1'b1, "send0_pending_stall");
        send_q.push_back('{2'd0, 2'd1});
        send_q.push_back('{2'd2, 2'd3});
        send_ready = 1'b1;
        step();
        step();
        send_ready = 1'b0;
        check("rr_drained_valid", {31'd0, send_valid}, 32'd0);

        // rr_ptr is now 3: channel 3 wins over channel 0
        wr_ok(32'h000C, 32'h30, "tx3_push");
        wr_ok(32'h0000, 32'h11, "tx0_push2");
        wr_ok(32'h0100, 32'd0, "send0_m0");
        wr_ok(32'h010C, 32'd1, "send3");
        check("rr_wrap_chan", {30'd0, send_chan}, 32'd3);
        send_q.push_back('{2'd3, 2'd1});
        send_q.push_back('{2'd0, 2'd0});
        send_ready = 1'b1;
        step();
        step();
        send_ready = 1'b0;
        tx_pop(2'd3, 32'h30);

        // single channel send and TX drain
        wr_ok(32'h0004, 32'hA1, "tx1_a1");
        wr_ok(32'h0004, 32'hA2, "tx1_a2");
        wr_ok(32'h0004, 32'hA3, "tx1_a3");
        wr_ok(32'h0104, 32'd2, "send1");
        check("send1_valid", {31'd0, send_valid}, 32'd1);
        check("send1_chan", {30'd0, send_chan}, 32'd1);
        check("send1_msg", {30'd0, send_msg}, 32'd2);
        send_q.push_back('{2'd1, 2'd2});
        send_ready = 1'b1;
        step();
        send_ready = 1'b0;
        check("send1_done_valid", {31'd0, send_valid}, 32'd0);
        rd_ok(32'h1008, 32'h4, "status_send_done");
        tx_pop(2'd1, 32'hA1);
        tx_pop(2'd1, 32'hA2);
        tx_pop(2'd1, 32'hA3);
        check("tx_empty_mix", {28'd0, tx_empty}, 32'hA);
        wr_ok(32'h1008, 32'h4, "status_w1c_send");
        rd_ok(32'h1008, 32'h0, "status_cleared");

        // send errors and decode errors
        wr_ok(32'h0004, 32'h55, "tx1_push55");
        bus(1'b1, 1'b0, 32'h0104, 32'd4, BAD, 1'b1, 1'b0, "send_msg_out_of_range");
        bus(1'b1, 1'b0, 32'h010C, 32'd1, BAD, 1'b1, 1'b0, "send_empty_chan");
        check("send_err_no_pending", {31'd0, send_valid}, 32'd0);
        bus(1'b1, 1'b0, 32'h2000, 32'd0, BAD, 1'b1, 1'b0, "wr_unmapped");
        bus(1'b0, 1'b1, 32'h2000, 32'd0, BAD, 1'b1, 1'b0, "rd_unmapped");
        bus(1'b1, 1'b0, 32'h0010, 32'd9, BAD, 1'b1, 1'b0, "wr_chan4_unmapped");
        bus(1'b1, 1'b1, 32'h1004, 32'd0, BAD, 1'b1, 1'b0, "wen_ren_both");
        bus(1'b0, 1'b1, 32'h0004, 32'd0, BAD, 1'b1, 1'b0, "rd_tx_window");
        config_done = 1'b1;
        rd_ok(32'h1010, 32'd1, "config_done");
        config_done = 1'b0;
        rd_ok(32'h1004, 32'd0, "rx_cnt_zero");
        bus(1'b0, 1'b1, 32'h1000, 32'd0, BAD, 1'b1, 1'b0, "rx_pop_empty");
        wr_ok(32'h100C, 32'h2, "mask_write");
        rd_ok(32'h100C, 32'h2, "mask_read");

        // TX FIFO full, error mode
        for (int i = 0; i < 16; i++) wr_ok(32'h000C, 32'hC000_0000 + i, "tx3_fill");
        bus(1'b1, 1'b0, 32'h000C, 32'hDEAD, BAD, 1'b1, 1'b0, "tx3_full_error");
        for (int i = 0; i < 16; i++) tx_pop(2'd3, 32'hC000_0000 + i);
        check("tx3_empty_after_drain", {31'd0, tx_empty[3]}, 32'd1);

        // RX overrun, irq and drain
        for (int i = 0; i < 17; i++) begin
            rx_wen = 1'b1;
            rx_wdata = 32'h5000_0000 + i;
            if (i == 16) check("rx_full_at_16", {31'd0, rx_full}, 32'd1);
            step();
        end
        rx_wen = 1'b0;
        check("irq_latency", {31'd0, irq}, 32'd0);
        step();
        check("irq_overrun", {31'd0, irq}, 32'd1);
        rd_ok(32'h1004, 32'd16, "rx_cnt_full");
        rd_ok(32'h1008, 32'h3, "status_overrun");
        wr_ok(32'h1008, 32'h2, "w1c_overrun");
        step();
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd_ok(32'h1008, 32'h1, "status_avail_only");
        for (int i = 0; i < 16; i++) rd_ok(32'h1000, 32'h5000_0000 + i, "rx_pop_data");
        bus(1'b0, 1'b1, 32'h1000, 32'd0, BAD, 1'b1, 1'b0, "rx_pop_underflow");

        // reset mid-operation
        for (int i = 0; i < 5; i++) wr_ok(32'h0000, 32'h100 + i, "tx0_queue");
        wr_ok(32'h0100, 32'd1, "send0_before_rst");
        rx_wen = 1'b1;
        rx_wdata = 32'h77;
        step();
        rx_wen = 1'b0;
        wr_ok(32'h100C, 32'h1, "mask_avail");
        step();
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        check("pre_rst_valid", {31'd0, send_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_send_valid", {31'd0, send_valid}, 32'd0);
        check("rst_mid_tx_empty", {28'd0, tx_empty}, 32'hF);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        check("rst_mid_rdata", rdata, BAD);
        #3;
        rst = 1'b0;
        step();
        rd_ok(32'h1004, 32'd0, "post_rst_rx_cnt");
        rd_ok(32'h1008, 32'd0, "post_rst_status");
        rd_ok(32'h100C, 32'd0, "post_rst_mask");

        // stall-on-full instance
        s_wen = 1'b1;
        s_addr = 32'h000C;
        for (int i = 0; i < 16; i++) begin
            s_wdata = 32'h7000_0000 + i;
            step();
        end
        s_wdata = 32'h99;
        check("stall_full", {31'd0, s_request_stall}, 32'd1);
        check("stall_no_error", {31'd0, s_error}, 32'd0);
        step();
        check("stall_hold", {31'd0, s_request_stall}, 32'd1);
        check("stall_head", s_tx_rdata[127:96], 32'h7000_0000);
        s_tx_ren = 4'b1000;
        step();
        s_tx_ren = 4'b0000;
        check("stall_release", {31'd0, s_request_stall}, 32'd0);
        step();
        s_wen = 1'b0;
        for (int i = 1; i < 16; i++) begin
            check("stall_drain", s_tx_rdata[127:96], 32'h7000_0000 + i);
            s_tx_ren = 4'b1000;
            step();
        end
        check("stall_last_word", s_tx_rdata[127:96], 32'h99);
        step();
        s_tx_ren = 4'b0000;
        check("stall_empty", {31'd0, s_tx_empty[3]}, 32'd1);

        repeat (3) step();
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("send_q_drained", send_q.size(), 32'd0);
        check("tx_q_drained", tx_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/endpoint_mmio_ctrl.md
Name: endpoint_mmio_ctrl

Overview:
Multi-channel successor to the endpoint bus front-end. It decodes a memory-mapped peripheral bus into NUM_CHAN independent TX staging FIFOs, one RX FIFO, a round-robin send-request queue toward the TX engine, and a maskable interrupt/status block. Full-FIFO handling is selectable: error response or stall. The block sits between the bus_protocol peripheral port and the tx/rx FSMs, and contains all FIFO storage internally.

Parameters:
NUM_CHAN, 4, number of TX channels (1..8)
NUM_MSGS, 4, valid message IDs 0..NUM_MSGS-1
DATA_WIDTH, 32, FIFO word width (<=32; bus rdata is zero-extended)
DEPTH, 16, entries per FIFO; power of 2, >=2
STALL_ON_FULL, 0, 1 = TX write to a full FIFO stalls; 0 = error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
addr  in  32  bus address
wen  in  1  bus write
ren  in  1  bus read
wdata  in  32  bus write data
rdata  out  32  bus read data (combinational)
error  out  1  bus error (combinational)
request_stall  out  1  bus stall (combinational)
tx_ren  in  NUM_CHAN  per-channel TX FIFO pop from TX engine
tx_rdata  out  NUM_CHAN*DATA_WIDTH  per-channel TX FIFO head, flattened; channel c occupies [c*DATA_WIDTH +: DATA_WIDTH]
tx_empty  out  NUM_CHAN  per-channel empty flag
send_valid  out  1  send request pending
send_chan  out  $clog2(NUM_CHAN)>0?$clog2(NUM_CHAN):1  granted channel
send_msg  out  $clog2(NUM_MSGS)>0?$clog2(NUM_MSGS):1  message ID for granted channel
send_ready  in  1  TX engine accepts request
rx_wen  in  1  RX FSM push
rx_wdata  in  DATA_WIDTH  RX push data
rx_full  out  1  RX FIFO full
config_done  in  1  configuration-complete flag
irq  out  1  interrupt

Behaviour:
- Reset: all FIFOs are empty, pending[] = 0, rr_ptr = 0, status = 0, mask = 0, irq = 0, send_valid = 0. Bus outputs idle: rdata = 32'hBAD1BAD1, error = 0, request_stall = 0. Reset asserted mid-operation drops all contents immediately.
- Bus response is combinational in the same cycle. State updates occur on the next clk edge.
- wen && ren together produce error=1 with no side effects.
- Address map (word-aligned). Any other address with wen or ren produces error=1:
  - 0x0000+4c (c<NUM_CHAN), write: push wdata[DATA_WIDTH-1:0] into TX FIFO c. If the FIFO is full: STALL_ON_FULL=1 gives request_stall=1; otherwise error=1. A full FIFO is never written.
  - 0x0100+4c, write: send request.
    - pending[c]=1 gives request_stall=1.
    - Otherwise, TX FIFO c empty or wdata>=NUM_MSGS gives error=1.
    - Otherwise set pending[c]=1 and msg_id[c]=wdata.
  - 0x1000, read: pop RX. If not empty, rdata = zero-extended head and the entry is popped. If empty, error=1.
  - 0x1004, read: rdata = RX count.
  - 0x1008, read: status. Bit0 RX_AVAIL (level, !rx_empty). Bit1 RX_OVERRUN (sticky). Bit2 SEND_DONE (sticky). Write: 1s clear bits 1 and 2 (W1C).
  - 0x100C, read/write: mask[2:0].
  - 0x1010, read: {31'd0, config_done}.
- FIFO counters are $clog2(DEPTH+1) bits. Read/write pointers wrap at DEPTH.
- TX FIFO c supports simultaneous push and pop; both take effect and count is unchanged. tx_ren on an empty FIFO is ignored.
- RX path:
  - rx_wen while rx_full: word dropped, RX_OVERRUN set. This applies even if the bus pops in the same cycle.
  - Simultaneous push and pop when not full: both take effect.
- Send arbiter:
  - send_valid = |pending.
  - Grant = first pending channel at or after rr_ptr, wrapping. send_chan and send_msg reflect the grant combinationally.
  - On send_valid && send_ready: clear pending[grant], rr_ptr <= grant+1 (mod NUM_CHAN), set SEND_DONE.
  - A bus send to channel c in the same cycle as acceptance of channel c sees pending[c]=1 and stalls.
- irq = |(status[2:0] & mask[2:0]), registered (one-cycle latency after the status change). W1C and a new set event in the same cycle: set wins.

Test Plan:
- Write 0xA1,0xA2,0xA3 to 0x0004, write 2 to 0x0104 -> next cycle send_valid=1, send_chan=1, send_msg=2. Hold send_ready=1 one cycle -> send_valid=0 and status=0x4. Pop 3 entries via tx_ren[1] -> tx_rdata shows 0xA1,0xA2,0xA3.
- Load channels 0 and 2, send msgs 1 and 3 together, send_ready held high -> grants chan0 then chan2, rr_ptr=3. A repeat send to chan0 while it is pending -> request_stall=1.
- Send with wdata=NUM_MSGS (4), or to an empty channel -> error=1, pending unchanged. Reads/writes to 0x2000 -> error=1, rdata=0xBAD1BAD1.
- DEPTH=16: 17 writes to chan3. STALL_ON_FULL=0 -> 17th write gives error=1, count=16. STALL_ON_FULL=1 -> stall until tx_ren[3], then the write completes.
- Push 17 RX words with mask=0x2 -> rx_full after 16, RX_OVERRUN=1, irq=1 one cycle later. Write 0x2 to 0x1008 -> irq=0. Then 16 reads of 0x1000 -> data in order, the 17th read gives error=1.
- Assert rst with 5 TX words queued and pending[0]=1 -> same cycle send_valid=0, tx_empty all 1s, irq=0.
